fg_decision: RTL and testbench

FG_DECISION -- requirements
Module: fg_decision

---
 rtl/fg_decision_pkg.sv | 20 ++
 rtl/cmp_gt.sv | 22 ++
 rtl/fg_decision.sv | 159 +++++++++++++++
 tb/tb_fg_decision.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fg_decision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fg_decision_pkg
// Description : Shared widths, latency and state encodings for the
//               foreground/background decision block.
// Revision    : 1.0 - initial release
// ============================================================================
package fg_decision_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;
    localparam int LAT_FG     = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmp_gt.sv
`default_nettype none
// ============================================================================
// Module      : cmp_gt
// Description : Registered unsigned greater-than compare, 1 cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_gt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    // Register a > b; consumers qualify the result with their own valid.
    always_ff @(posedge clk) begin
        gt <= (a > b);
    end

endmodule
`default_nettype wire

// File: rtl/fg_decision.sv
`default_nettype none
// ============================================================================
// Module      : fg_decision
// Description : Counts background samples closer than R to a pixel, tracks
//               the minimum distance and decides foreground/background.
//               Stage 0: FSM + registered compare; stage 1: accumulate/issue.
// Revision    : 1.0 - initial release
// ============================================================================
module fg_decision
    import fg_decision_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sv,
    input  logic              sfirst,
    input  logic              slast,
    input  logic [DATA_W-1:0] sd,
    input  logic [DATA_W-1:0] r,
    input  logic [CNT_W-1:0]  nmin,
    output logic              fv,
    output logic              fg,
    output logic [DATA_W-1:0] dmin,
    output logic [CNT_W-1:0]  cnt,
    output logic              err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    logic [DATA_W-1:0]   r_thr;
    logic [CNT_W-1:0]    r_nmin;
    logic                r_p_valid;
    logic                r_p_init;
    logic                r_p_last;
    logic [DATA_W-1:0]   r_sd;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [DATA_W-1:0]   r_acc_min;
    logic                w_match;
    logic                w_start;
    logic [DATA_W-1:0]   w_thr_cmp;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [DATA_W-1:0]   w_min_next;

    // Any sfirst beat opens a new pixel, whether from IDLE or as a restart.
    assign w_start = sv & sfirst;

    // The first beat must compare against its own R, not the stale latch.
    assign w_thr_cmp = w_start ? r : r_thr;

    // Match iff sd < R, i.e. R > sd.
    cmp_gt #(
        .W (DATA_W)
    ) u_cmp_gt (
        .clk (clk),
        .a   (w_thr_cmp),
        .b   (sd),
        .gt  (w_match)
    );

    // Per-pixel threshold and minimum count; no reset needed.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_thr  <= r;
            r_nmin <= nmin;
        end
        r_sd <= sd;
    end

    // Protocol FSM: classifies each beat into accumulate/init/issue tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_p_valid <= 1'b0;
            r_p_init  <= 1'b0;
            r_p_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_p_valid <= 1'b0;
            r_p_init  <= 1'b0;
            r_p_last  <= 1'b0;
            err       <= 1'b0;
            if (sv) begin
                case (r_state)
                    ST_IDLE: begin
                        if (sfirst) begin
                            r_p_valid <= 1'b1;
                            r_p_init  <= 1'b1;
                            r_p_last  <= slast;
                            r_state   <= slast ? ST_IDLE : ST_ACC;
                        end else if (slast) begin
                            err <= 1'b1;
                        end
                    end
                    ST_ACC: begin
                        if (sfirst) begin
                            // Abandon the partial pixel and restart here.
                            err       <= 1'b1;
                            r_p_valid <= 1'b1;
                            r_p_init  <= 1'b1;
                            r_p_last  <= slast;
                            r_state   <= slast ? ST_IDLE : ST_ACC;
                        end else begin
                            r_p_valid <= 1'b1;
                            r_p_last  <= slast;
                            r_state   <= slast ? ST_IDLE : ST_ACC;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Next accumulator values: initialise on the first beat, else saturate/min.
    always_comb begin
        w_cnt_next = r_acc_cnt;
        w_min_next = r_acc_min;
        if (r_p_init) begin
            w_cnt_next = CNT_W'(w_match);
            w_min_next = r_sd;
        end else begin
            if (w_match && (r_acc_cnt != C_CNT_MAX)) begin
                w_cnt_next = r_acc_cnt + 1'b1;
            end
            if (r_sd < r_acc_min) begin
                w_min_next = r_sd;
            end
        end
    end

    // Accumulate stage; results are issued and held until the next pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt <= '0;
            r_acc_min <= '0;
            fv        <= 1'b0;
            fg        <= 1'b0;
            cnt       <= '0;
            dmin      <= '0;
        end else begin
            fv <= 1'b0;
            if (r_p_valid) begin
                r_acc_cnt <= w_cnt_next;
                r_acc_min <= w_min_next;
                if (r_p_last) begin
                    fv   <= 1'b1;
                    cnt  <= w_cnt_next;
                    dmin <= w_min_next;
                    fg   <= (w_cnt_next < r_nmin);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fg_decision.sv
`default_nettype none
// ============================================================================
// Module      : tb_fg_decision
// Description : Scoreboard bench for fg_decision with directed pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fg_decision;
    import fg_decision_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sv = 1'b0;
    logic        sfirst = 1'b0;
    logic        slast = 1'b0;
    logic [15:0] sd = '0;
    logic [15:0] r = '0;
    logic [7:0]  nmin = '0;
    logic        fv;
    logic        fg;
    logic [15:0] dmin;
    logic [7:0]  cnt;
    logic        err;

    typedef struct {
        int cyc;
        int cnt;
        int fg;
        int dmin;
    } exp_t;

    exp_t q_px[$];
    int   q_err[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    fg_decision #(
        .DATA_W (16),
        .CNT_W  (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sv     (sv),
        .sfirst (sfirst),
        .slast  (slast),
        .sd     (sd),
        .r      (r),
        .nmin   (nmin),
        .fv     (fv),
        .fg     (fg),
        .dmin   (dmin),
        .cnt    (cnt),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input logic f, input logic l, input logic [15:0] d,
                         input logic [15:0] rr, input logic [7:0] nm);
        @(posedge clk);
        #1;
        sv = 1'b1; sfirst = f; slast = l; sd = d; r = rr; nmin = nm;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sv = 1'b0; sfirst = 1'b0; slast = 1'b0;
        end
    endtask

    // Called right after the slast beat is driven.
    task automatic expect_px(input int c, input int f, input int d);
        exp_t e;
        e.cyc = cyc + LAT_FG; e.cnt = c; e.fg = f; e.dmin = d;
        q_px.push_back(e);
    endtask

    task automatic expect_err();
        q_err.push_back(cyc + 1);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_fv"},   int'(fv),   0);
        check({tag, "_err"},  int'(err),  0);
        check({tag, "_fg"},   int'(fg),   0);
        check({tag, "_cnt"},  int'(cnt),  0);
        check({tag, "_dmin"}, int'(dmin), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents fv or err.
    initial begin
        forever begin
            @(negedge clk);
            if (fv) begin
                if (q_px.size() == 0) begin
                    check("unexpected_fv", 1, 0);
                end else begin
                    exp_t e;
                    e = q_px.pop_front();
                    check("fv_cycle", cyc, e.cyc);
                    check("cnt", int'(cnt), e.cnt);
                    check("fg", int'(fg), e.fg);
                    check("dmin", int'(dmin), e.dmin);
                end
            end
            if (err) begin
                if (q_err.size() == 0) begin
                    check("unexpected_err", 1, 0);
                end else begin
                    int ec;
                    ec = q_err.pop_front();
                    check("err_cycle", cyc, ec);
                end
            end
        end
    end

    initial begin
        int budget;
        idle(3);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // r=100 nmin=2: 50,100,150,30 -> cnt 2, fg 0, dmin 30
        drive(1'b1, 1'b0, 16'd50, 16'd100, 8'd2);
        drive(1'b0, 1'b0, 16'd100, 16'd0, 8'd0);
        drive(1'b0, 1'b0, 16'd150, 16'd0, 8'd0);
        drive(1'b0, 1'b1, 16'd30, 16'd0, 8'd0);
        expect_px(2, 0, 30);
        // Back-to-back, with a gap inside: r=10 nmin=3: 20,5,40 -> cnt 1, fg 1, dmin 5
        drive(1'b1, 1'b0, 16'd20, 16'd10, 8'd3);
        idle(1);
        drive(1'b0, 1'b0, 16'd5, 16'd0, 8'd0);
        drive(1'b0, 1'b1, 16'd40, 16'd0, 8'd0);
        expect_px(1, 1, 5);
        idle(1);
        // Middle beat in IDLE is ignored silently
        drive(1'b0, 1'b0, 16'd7, 16'd0, 8'd0);
        idle(1);
        // Single-sample pixel: sd=0 r=1 nmin=1 -> cnt 1, fg 0, dmin 0
        drive(1'b1, 1'b1, 16'd0, 16'd1, 8'd1);
        expect_px(1, 0, 0);
        idle(1);
        // sd equal to r does not match: r=8 nmin=1 sd 8,8 -> cnt 0, fg 1, dmin 8
        drive(1'b1, 1'b0, 16'd8, 16'd8, 8'd1);
        drive(1'b0, 1'b1, 16'd8, 16'd0, 8'd0);
        expect_px(0, 1, 8);
        idle(1);
        // Restart mid-pixel: only 200,20 with r=100 nmin=1 count -> cnt 1, fg 0, dmin 20
        drive(1'b1, 1'b0, 16'd5, 16'd100, 8'd1);
        drive(1'b0, 1'b0, 16'd6, 16'd0, 8'd0);
        drive(1'b1, 1'b0, 16'd200, 16'd100, 8'd1);
        expect_err();
        drive(1'b0, 1'b1, 16'd20, 16'd0, 8'd0);
        expect_px(1, 0, 20);
        idle(1);
        // slast in IDLE: error only
        drive(1'b0, 1'b1, 16'd9, 16'd0, 8'd0);
        expect_err();
        idle(3);
        // Saturation: 300 samples sd=0 r=1 nmin=5 -> cnt 255, fg 0, dmin 0
        drive(1'b1, 1'b0, 16'd0, 16'd1, 8'd5);
        for (int i = 0; i < 298; i++) drive(1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
        drive(1'b0, 1'b1, 16'd0, 16'd0, 8'd0);
        expect_px(255, 0, 0);
        idle(5);
        // Reset in ACC drops the partial pixel; outputs clear
        drive(1'b1, 1'b0, 16'd70, 16'd50, 8'd1);
        drive(1'b0, 1'b0, 16'd3, 16'd0, 8'd0);
        @(posedge clk);
        #1;
        sv = 1'b0; sfirst = 1'b0; slast = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("midrst");
        // Fresh 2-sample pixel: r=50 nmin=1: 60,10 -> cnt 1, fg 0, dmin 10
        drive(1'b1, 1'b0, 16'd60, 16'd50, 8'd1);
        drive(1'b0, 1'b1, 16'd10, 16'd0, 8'd0);
        expect_px(1, 0, 10);
        idle(1);

        budget = 0;
        while ((q_px.size() != 0 || q_err.size() != 0) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        idle(4);
        check("pending_px", q_px.size(), 0);
        check("pending_err", q_err.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
